// File: rtl/banked_memory_ctrl.sv
// Banked register memory with one write port, two registered read ports,
// a zero-fill clear sequencer and optional read-during-write bypass.
module banked_memory_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int SECTOR_WIDTH = 4,
  parameter int NUM_SECTORS  = 16,
  parameter int BYPASS       = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [SECTOR_WIDTH-1:0] wr_sector,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  input  logic                    rd_en_1,
  input  logic [SECTOR_WIDTH-1:0] rd_sector_1,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_1,
  output logic [DATA_WIDTH-1:0]   rd_data_1,
  output logic                    rd_valid_1,
  input  logic                    rd_en_2,
  input  logic [SECTOR_WIDTH-1:0] rd_sector_2,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_2,
  output logic [DATA_WIDTH-1:0]   rd_data_2,
  output logic                    rd_valid_2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [SECTOR_WIDTH:0] SECTOR_LIMIT = (SECTOR_WIDTH + 1)'(NUM_SECTORS);
  localparam logic [ADDR_WIDTH:0]   CLR_LAST     = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CLR_ONE      = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH:0]   clr_cnt_reg, clr_cnt_next;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_fire;

  // Read ports gathered into arrays so both share one generate body.
  logic                    rd_en     [2];
  logic [SECTOR_WIDTH-1:0] rd_sector [2];
  logic [ADDR_WIDTH-1:0]   rd_addr   [2];
  logic [DATA_WIDTH-1:0]   rd_data_q [2];
  logic                    rd_valid_q[2];
  logic [DATA_WIDTH-1:0]   word      [2][NUM_SECTORS];

  assign rd_en[0]     = rd_en_1;
  assign rd_en[1]     = rd_en_2;
  assign rd_sector[0] = rd_sector_1;
  assign rd_sector[1] = rd_sector_2;
  assign rd_addr[0]   = rd_addr_1;
  assign rd_addr[1]   = rd_addr_2;
  assign rd_data_1    = rd_data_q[0];
  assign rd_data_2    = rd_data_q[1];
  assign rd_valid_1   = rd_valid_q[0];
  assign rd_valid_2   = rd_valid_q[1];

  assign busy     = (state_reg == CLEAR);
  assign wr_ready = ~busy;
  assign clr_addr = clr_cnt_reg[ADDR_WIDTH-1:0];
  assign wr_fire  = wr_en & wr_ready & ~reset & ({1'b0, wr_sector} < SECTOR_LIMIT);

  // State and clear-counter registers; reset restarts the clear sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Next-state: walk every address once in CLEAR, then sit in READY.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + CLR_ONE;
        if (clr_cnt_reg == CLR_LAST) begin
          state_next   = READY;
          clr_cnt_next = '0;
        end
      end
      READY: begin
        if (clear_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_SECTORS; gi++) begin : g_sector
      logic [DATA_WIDTH-1:0] sector_mem [DEPTH];

      // Clear zeroes one address in every sector at once; otherwise accept writes.
      always_ff @(posedge clock) begin
        if (busy) begin
          sector_mem[clr_addr] <= '0;
        end else if (wr_fire && (wr_sector == SECTOR_WIDTH'(gi))) begin
          sector_mem[wr_addr] <= wr_data;
        end
      end

      assign word[0][gi] = sector_mem[rd_addr[0]];
      assign word[1][gi] = sector_mem[rd_addr[1]];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic                  in_range;
      logic                  hit;
      logic [DATA_WIDTH-1:0] rd_next;

      assign in_range = ({1'b0, rd_sector[gi]} < SECTOR_LIMIT);
      assign hit      = (BYPASS != 0) && wr_fire &&
                        (rd_sector[gi] == wr_sector) && (rd_addr[gi] == wr_addr);

      // Memory reads as zero while clearing or for an absent sector.
      always_comb begin
        rd_next = '0;
        if (!busy && in_range) begin
          rd_next = hit ? wr_data : word[gi][rd_sector[gi]];
        end
      end

      // Registered read data; data holds when no read is requested.
      always_ff @(posedge clock) begin
        if (reset) begin
          rd_data_q[gi]  <= '0;
          rd_valid_q[gi] <= 1'b0;
        end else begin
          rd_valid_q[gi] <= rd_en[gi];
          if (rd_en[gi]) begin
            rd_data_q[gi] <= rd_next;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_banked_memory_ctrl.sv
// Scoreboard bench: DUT A (16 sectors, bypass) and DUT B (12 sectors, no bypass)
// share one stimulus stream; each read pushes hand-computed data per DUT.
module tb_banked_memory_ctrl;

  logic        clock = 1'b0;
  logic        reset, clear_req, wr_en, rd_en_1, rd_en_2;
  logic [3:0]  wr_sector, wr_addr, rd_sector_1, rd_addr_1, rd_sector_2, rd_addr_2;
  logic [15:0] wr_data;

  logic        a_busy, a_wr_ready, a_rv1, a_rv2;
  logic [15:0] a_rd1, a_rd2;
  logic        b_busy, b_wr_ready, b_rv1, b_rv2;
  logic [15:0] b_rd1, b_rd2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  // Queues: 0 = A port1, 1 = A port2, 2 = B port1, 3 = B port2.
  exp_t        q [4][$];
  logic        vld [4];
  logic [15:0] dat [4];

  assign vld[0] = a_rv1;
  assign vld[1] = a_rv2;
  assign vld[2] = b_rv1;
  assign vld[3] = b_rv2;
  assign dat[0] = a_rd1;
  assign dat[1] = a_rd2;
  assign dat[2] = b_rd1;
  assign dat[3] = b_rd2;

  banked_memory_ctrl #(.NUM_SECTORS(16), .BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(a_busy),
    .wr_en(wr_en), .wr_sector(wr_sector), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(a_wr_ready),
    .rd_en_1(rd_en_1), .rd_sector_1(rd_sector_1), .rd_addr_1(rd_addr_1),
    .rd_data_1(a_rd1), .rd_valid_1(a_rv1),
    .rd_en_2(rd_en_2), .rd_sector_2(rd_sector_2), .rd_addr_2(rd_addr_2),
    .rd_data_2(a_rd2), .rd_valid_2(a_rv2)
  );

  banked_memory_ctrl #(.NUM_SECTORS(12), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .clear_req(clear_req), .busy(b_busy),
    .wr_en(wr_en), .wr_sector(wr_sector), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(b_wr_ready),
    .rd_en_1(rd_en_1), .rd_sector_1(rd_sector_1), .rd_addr_1(rd_addr_1),
    .rd_data_1(b_rd1), .rd_valid_1(b_rv1),
    .rd_en_2(rd_en_2), .rd_sector_2(rd_sector_2), .rd_addr_2(rd_addr_2),
    .rd_data_2(b_rd2), .rd_valid_2(b_rv2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Monitor: on the falling edge compare every presented read with the queue.
  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      logic exp_v;
      exp_v = (q[k].size() > 0) && (q[k][0].due == cyc);
      if (vld[k] || exp_v) begin
        checks++;
        if (vld[k] !== exp_v) begin
          errors++;
          $display("FAIL rd_valid[q%0d] cycle %0d: got %b expected %b", k, cyc, vld[k], exp_v);
        end else if (dat[k] !== q[k][0].data) begin
          errors++;
          $display("FAIL rd_data[q%0d] cycle %0d: got %h expected %h", k, cyc, dat[k], q[k][0].data);
        end else begin
          $display("read q%0d cycle %0d data %h ok", k, cyc, dat[k]);
        end
        if (exp_v) void'(q[k].pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    wr_en     = 1'b0;
    rd_en_1   = 1'b0;
    rd_en_2   = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic set_wr(input logic [3:0] s, input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_sector = s; wr_addr = a; wr_data = d;
  endtask

  // Port-1 read with expected data for DUT A and DUT B.
  task automatic rd1(input logic [3:0] s, input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    rd_en_1 = 1'b1; rd_sector_1 = s; rd_addr_1 = a;
    e.due = cyc + 1;
    e.data = ea; q[0].push_back(e);
    e.data = eb; q[2].push_back(e);
  endtask

  task automatic rd2(input logic [3:0] s, input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
    exp_t e;
    rd_en_2 = 1'b1; rd_sector_2 = s; rd_addr_2 = a;
    e.due = cyc + 1;
    e.data = ea; q[1].push_back(e);
    e.data = eb; q[3].push_back(e);
  endtask

  task automatic expect_busy(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_busy_a"}, {31'd0, a_busy}, 32'd1);
      chk({tag, "_busy_b"}, {31'd0, b_busy}, 32'd1);
      tick();
    end
    chk({tag, "_done_a"}, {31'd0, a_busy}, 32'd0);
    chk({tag, "_done_b"}, {31'd0, b_busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0; rd_en_1 = 1'b0; rd_en_2 = 1'b0;
    wr_sector = '0; wr_addr = '0; wr_data = '0;
    rd_sector_1 = '0; rd_addr_1 = '0; rd_sector_2 = '0; rd_addr_2 = '0;
    tick();

    chk("reset_busy",     {31'd0, a_busy},     32'd1);
    chk("reset_wr_ready", {31'd0, a_wr_ready}, 32'd0);
    chk("reset_rd_data_1", {16'd0, a_rd1},     32'd0);
    chk("reset_rd_data_2", {16'd0, a_rd2},     32'd0);
    chk("reset_rd_valid_1", {31'd0, a_rv1},    32'd0);
    chk("reset_rd_valid_2", {31'd0, a_rv2},    32'd0);
    reset = 1'b0;

    // Initial clear: exactly 16 busy cycles; a read during busy returns zero.
    for (int i = 0; i < 16; i++) begin
      chk("init_busy", {31'd0, a_busy}, 32'd1);
      if (i == 3) rd1(4'd2, 4'd2, 16'h0000, 16'h0000);
      tick();
    end
    chk("init_done",     {31'd0, a_busy},     32'd0);
    chk("init_wr_ready", {31'd0, a_wr_ready}, 32'd1);

    // Every location reads zero after clear.
    for (int s = 0; s < 16; s++) begin
      for (int a = 0; a < 16; a++) begin
        rd1(4'(s), 4'(a), 16'h0000, 16'h0000);
        rd2(4'(15 - s), 4'(a), 16'h0000, 16'h0000);
        tick();
      end
    end

    // Two writes, then dual read; sector 15 is absent in DUT B.
    set_wr(4'd3, 4'd7, 16'hA5A5);  tick();
    set_wr(4'd15, 4'd0, 16'h1234); tick();
    rd1(4'd3, 4'd7, 16'hA5A5, 16'hA5A5);
    rd2(4'd15, 4'd0, 16'h1234, 16'h0000);
    tick();

    // Read-during-write on port 1 and on port 2.
    set_wr(4'd5, 4'd2, 16'hBEEF);
    rd1(4'd5, 4'd2, 16'hBEEF, 16'h0000);
    tick();
    set_wr(4'd6, 4'd1, 16'hCAFE);
    rd2(4'd6, 4'd1, 16'hCAFE, 16'h0000);
    tick();
    rd1(4'd5, 4'd2, 16'hBEEF, 16'hBEEF);
    rd2(4'd5, 4'd2, 16'hBEEF, 16'hBEEF);
    tick();
    tick();
    chk("hold_rd_data_1",  {16'd0, a_rd1}, 32'h0000BEEF);
    chk("hold_rd_valid_1", {31'd0, a_rv1}, 32'd0);

    // Sector 13 exists in A only; B drops the write and reads zero.
    set_wr(4'd13, 4'd4, 16'h7777); tick();
    rd1(4'd13, 4'd4, 16'h7777, 16'h0000);
    tick();
    for (int s = 0; s < 12; s++) begin
      rd2(4'(s), 4'd4, 16'h0000, 16'h0000);
      tick();
    end
    rd1(4'd3, 4'd7, 16'hA5A5, 16'hA5A5);
    tick();

    // Requested clear: write during busy dropped, clear_req mid-sequence ignored.
    set_wr(4'd0, 4'd0, 16'h1111); tick();
    rd1(4'd0, 4'd0, 16'h1111, 16'h1111);
    clear_req = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("clr_busy", {31'd0, a_busy}, 32'd1);
      if (i == 0) begin
        chk("clr_wr_ready", {31'd0, a_wr_ready}, 32'd0);
        set_wr(4'd0, 4'd1, 16'h2222);
      end
      if (i == 8) clear_req = 1'b1;
      tick();
    end
    chk("clr_done", {31'd0, a_busy}, 32'd0);
    rd1(4'd0, 4'd0, 16'h0000, 16'h0000);
    rd2(4'd0, 4'd1, 16'h0000, 16'h0000);
    tick();

    // Reset partway through a clear restarts it from the beginning.
    set_wr(4'd9, 4'd9, 16'h9999); tick();
    clear_req = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_busy("rst_mid");
    rd1(4'd9, 4'd9, 16'h0000, 16'h0000);
    rd2(4'd3, 4'd7, 16'h0000, 16'h0000);
    tick();

    tick();
    tick();
    chk("scoreboard_drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banked_memory_ctrl.md
Name: banked_memory_ctrl

Overview:
- Parametrised multi-sector register memory with one write port and two independent registered read ports.
- Each port selects a sector plus an in-sector address.
- Adds a hardware clear sequencer that zero-fills all sectors after reset or on request, plus read-valid strobes and configurable read-during-write bypass.
- Serves as the weight/activation store feeding the autoencoder MAC datapath.

Parameters:
- DATA_WIDTH, 16, bits per word.
- ADDR_WIDTH, 4, in-sector address bits; DEPTH = 2**ADDR_WIDTH words per sector.
- SECTOR_WIDTH, 4, sector-select bits.
- NUM_SECTORS, 16, instantiated sectors; must be <= 2**SECTOR_WIDTH.
- BYPASS, 1, 1 = same-cycle read of the location being written returns new data; 0 = returns old data.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- clear_req  input  1  pulse: start zero-fill of all sectors
- busy  output  1  high while clear sequence runs
- wr_en  input  1  write strobe
- wr_sector  input  SECTOR_WIDTH  write sector select
- wr_addr  input  ADDR_WIDTH  write address within sector
- wr_data  input  DATA_WIDTH  write data
- wr_ready  output  1  = ~busy; writes accepted only when high
- rd_en_1  input  1  read request, port 1
- rd_sector_1  input  SECTOR_WIDTH  sector select, port 1
- rd_addr_1  input  ADDR_WIDTH  address, port 1
- rd_data_1  output  DATA_WIDTH  registered read data, port 1
- rd_valid_1  output  1  rd_data_1 valid strobe
- rd_en_2, rd_sector_2, rd_addr_2, rd_data_2, rd_valid_2: identical to port 1, for port 2

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on the rising edge of clock.
- Reset:
  - FSM enters CLEAR; clr_cnt=0.
  - busy=1, wr_ready=0.
  - rd_data_1/2=0, rd_valid_1/2=0.
  - Array contents are not reset directly; the clear sequence zeroes them.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to address clr_cnt in every sector in parallel, then clr_cnt++. When clr_cnt==DEPTH-1 is written, go to READY next cycle. Duration is exactly DEPTH cycles; busy deasserts on the cycle after the last clear write.
  - READY: normal operation. clear_req=1 -> CLEAR with clr_cnt=0 on the next edge.
  - clear_req during CLEAR is ignored; the sequence is not restarted.
  - reset asserted mid-CLEAR restarts the sequence at clr_cnt=0.
- Write:
  - When wr_en & wr_ready & (wr_sector < NUM_SECTORS), mem[wr_sector][wr_addr] <= wr_data at the edge.
  - An out-of-range sector is silently dropped.
  - wr_en while busy is dropped, with no side effect.
- Read (per port, independent):
  - Latency 1. rd_en at edge N -> rd_data and rd_valid=1 after edge N.
  - rd_en=0 -> rd_valid=0 next cycle; rd_data holds its last value.
  - Out-of-range sector: rd_data=0, rd_valid=1.
  - Read while busy: rd_data=0, rd_valid=1; the array is treated as zero during clear.
  - Both ports may read the same location in the same cycle; identical data is returned.
- Read-during-write (same sector and address, same edge):
  - BYPASS=1: rd_data = wr_data.
  - BYPASS=0: rd_data = previous contents.
  - Applies to each port independently.
- Widths: no arithmetic on data; clr_cnt is ADDR_WIDTH+1 bits so terminal detection does not wrap.

Test Plan:
- Reset 1 cycle, then hold idle -> busy=1 for exactly 16 cycles, then busy=0. A read of every sector/address returns 0x0000 with rd_valid=1 one cycle after rd_en.
- After clear, write 0xA5A5 to sector 3 addr 7 and 0x1234 to sector 15 addr 0. Read port 1 (3,7) and port 2 (15,0) in the same cycle -> next cycle rd_data_1=0xA5A5, rd_data_2=0x1234, both valid.
- Write 0xBEEF to (5,2) while rd_en_1 reads (5,2) in the same cycle, with old contents 0x0000 -> BYPASS=1 gives rd_data_1=0xBEEF; BYPASS=0 gives 0x0000. A read the following cycle gives 0xBEEF in both cases.
- Fill (0,0)=0x1111. Pulse clear_req, attempt a write of 0x2222 to (0,1) during busy -> wr_ready=0 and the write is dropped. After 16 cycles, reads of (0,0) and (0,1) return 0x0000.
- Assert reset at clear cycle 8 -> busy remains 1 and completes 16 cycles after reset release; the sequence restarts from 0.
- NUM_SECTORS=12: write 0x7777 to sector 13 -> dropped. A read of sector 13 returns 0x0000 with valid. Sectors 0–11 are unaffected.
